iir_sos_tdm_wb: RTL and testbench

- Wishbone-slave cascaded-biquad IIR filter with NUM_SECTIONS configurable Direct Form I sections.
- Uses one time-multiplexed multiplier-accumulator instead of one multiplier per tap.
- Adds a busy/done handshake, a dropped-sample flag, a state-clear control, a coefficient-write guard and an interrupt output.
- Sits on the peripheral Wishbone bus. Software writes a sample, polls the done flag or takes the interrupt, then reads the result.

---
 rtl/iir_sos_tdm_wb.sv | 258 +++++++++++++++++++++++++
 tb/tb_iir_sos_tdm_wb.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_sos_tdm_wb.sv
// rtl/iir_sos_tdm_wb.sv - Wishbone cascaded Direct Form I biquad IIR filter built on one shared MAC
// Each section takes five MAC cycles and one saturate/update cycle; a result takes 6*NUM_SECTIONS+1 cycles.
module iir_sos_tdm_wb #(
  parameter int DATA_WIDTH   = 32,
  parameter int COEFF_WIDTH  = 32,
  parameter int ACC_WIDTH    = 64,
  parameter int SCALE_SHIFT  = 20,
  parameter int NUM_SECTIONS = 3,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  input  logic                  wb_we_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_cyc_i,
  output logic                  wb_ack_o,
  output logic                  irq_o
);

  localparam int NC  = NUM_SECTIONS * 5;
  localparam int CIW = $clog2(NC);
  localparam int SW  = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1;
  localparam int AW2 = ADDR_WIDTH - 2;

  localparam logic [SW-1:0]                LAST = SW'(NUM_SECTIONS - 1);
  localparam logic [CIW-1:0]               FIVE = CIW'(5);
  localparam logic signed [COEFF_WIDTH-1:0] ONE = COEFF_WIDTH'(1) << SCALE_SHIFT;
  localparam logic signed [ACC_WIDTH-1:0]  VMAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0]  VMIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_SAT, S_DONE} state_t;

  logic                          r_ack;
  logic [DATA_WIDTH-1:0]         r_dat;
  logic signed [DATA_WIDTH-1:0]  r_x;
  logic signed [DATA_WIDTH-1:0]  r_y;
  logic signed [DATA_WIDTH-1:0]  r_x1 [NUM_SECTIONS];
  logic signed [DATA_WIDTH-1:0]  r_x2 [NUM_SECTIONS];
  logic signed [DATA_WIDTH-1:0]  r_y1 [NUM_SECTIONS];
  logic signed [DATA_WIDTH-1:0]  r_y2 [NUM_SECTIONS];
  logic signed [COEFF_WIDTH-1:0] r_coef [NC];
  logic                          r_enable;
  logic                          r_irq_en;
  logic                          r_done;
  logic                          r_drop;
  logic                          r_cfg_err;
  logic [NUM_SECTIONS-1:0]       r_ovf;
  state_t                        r_state;
  logic [SW-1:0]                 r_s;
  logic [2:0]                    r_k;
  logic signed [ACC_WIDTH-1:0]   r_acc;

  logic                          w_req;
  logic                          w_wr;
  logic [AW2-1:0]                w_word;
  logic [AW2-1:0]                w_cword;
  logic                          w_aligned;
  logic                          w_sel_x;
  logic                          w_sel_y;
  logic                          w_sel_stat;
  logic                          w_sel_ctrl;
  logic                          w_sel_coef;
  logic [CIW-1:0]                w_bus_cidx;
  logic                          w_busy;
  logic                          w_start;
  logic                          w_clr_state;
  logic                          w_stat_clr;
  logic                          w_drop_set;
  logic                          w_cfg_set;
  logic                          w_done_set;
  logic [NUM_SECTIONS-1:0]       w_ovf_set;
  logic [DATA_WIDTH-1:0]         w_rdata;
  logic signed [DATA_WIDTH-1:0]  w_xin;
  logic signed [DATA_WIDTH-1:0]  w_opnd;
  logic [CIW-1:0]                w_cur_idx;
  logic signed [COEFF_WIDTH-1:0] w_coef;
  logic signed [ACC_WIDTH-1:0]   w_coef_ext;
  logic signed [ACC_WIDTH-1:0]   w_opnd_ext;
  logic signed [ACC_WIDTH-1:0]   w_prod;
  logic signed [ACC_WIDTH-1:0]   w_acc_next;
  logic signed [ACC_WIDTH-1:0]   w_v;
  logic                          w_hi;
  logic                          w_lo;
  logic signed [DATA_WIDTH-1:0]  w_sat;

  // Bus decode: one request per transfer, ack high blocks re-acceptance.
  assign w_req      = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr       = w_req & wb_we_i;
  assign w_word     = wb_adr_i[ADDR_WIDTH-1:2];
  assign w_aligned  = (wb_adr_i[1:0] == 2'b00);
  assign w_cword    = w_word - AW2'(4);
  assign w_sel_x    = w_aligned && (w_word == AW2'(0));
  assign w_sel_y    = w_aligned && (w_word == AW2'(1));
  assign w_sel_stat = w_aligned && (w_word == AW2'(2));
  assign w_sel_ctrl = w_aligned && (w_word == AW2'(3));
  assign w_sel_coef = w_aligned && (w_word >= AW2'(4)) && (w_cword < AW2'(NC));
  assign w_bus_cidx = CIW'(w_cword);

  assign w_busy      = (r_state != S_IDLE);
  assign w_start     = w_wr & w_sel_x & ~w_busy & r_enable;
  assign w_clr_state = w_wr & w_sel_ctrl & wb_dat_i[1];
  assign w_stat_clr  = w_req & w_sel_stat;
  assign w_drop_set  = w_wr & w_sel_x & w_busy;
  assign w_cfg_set   = w_wr & w_sel_coef & w_busy;
  assign w_done_set  = (r_state == S_DONE) & ~w_clr_state;

  // Section input is the sample for section 0, else the freshly written y1 of the section before.
  assign w_xin      = (r_s == '0) ? r_x : r_y1[r_s - SW'(1)];
  assign w_cur_idx  = CIW'(r_s) * FIVE + CIW'(r_k);
  assign w_coef     = r_coef[w_cur_idx];

  always_comb begin
    w_opnd = w_xin;
    case (r_k)
      3'd1:    w_opnd = r_x1[r_s];
      3'd2:    w_opnd = r_x2[r_s];
      3'd3:    w_opnd = r_y1[r_s];
      3'd4:    w_opnd = r_y2[r_s];
      default: w_opnd = w_xin;
    endcase
  end

  assign w_coef_ext = {{(ACC_WIDTH-COEFF_WIDTH){w_coef[COEFF_WIDTH-1]}}, w_coef};
  assign w_opnd_ext = {{(ACC_WIDTH-DATA_WIDTH){w_opnd[DATA_WIDTH-1]}}, w_opnd};
  assign w_prod     = w_coef_ext * w_opnd_ext;
  assign w_acc_next = (r_k >= 3'd3) ? (r_acc - w_prod) : (r_acc + w_prod);

  assign w_v   = r_acc >>> SCALE_SHIFT;
  assign w_hi  = (w_v > VMAX);
  assign w_lo  = (w_v < VMIN);
  assign w_sat = w_hi ? {1'b0, {(DATA_WIDTH-1){1'b1}}} :
                 w_lo ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : w_v[DATA_WIDTH-1:0];
  assign w_ovf_set = ((r_state == S_SAT) && (w_hi || w_lo)) ?
                     (NUM_SECTIONS'(1) << r_s) : '0;

  always_comb begin
    w_rdata = '0;
    if (w_sel_x) begin
      w_rdata = r_x;
    end else if (w_sel_y) begin
      w_rdata = r_y;
    end else if (w_sel_stat) begin
      w_rdata[0]                 = w_busy;
      w_rdata[1]                 = r_done;
      w_rdata[2]                 = r_drop;
      w_rdata[3]                 = r_cfg_err;
      w_rdata[8 +: NUM_SECTIONS] = r_ovf;
    end else if (w_sel_ctrl) begin
      w_rdata[0] = r_enable;
      w_rdata[2] = r_irq_en;
    end else if (w_sel_coef) begin
      w_rdata = DATA_WIDTH'(r_coef[w_bus_cidx]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack     <= 1'b0;
      r_dat     <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_enable  <= 1'b1;
      r_irq_en  <= 1'b0;
      r_done    <= 1'b0;
      r_drop    <= 1'b0;
      r_cfg_err <= 1'b0;
      r_ovf     <= '0;
      r_state   <= S_IDLE;
      r_s       <= '0;
      r_k       <= '0;
      r_acc     <= '0;
      for (int i = 0; i < NUM_SECTIONS; i++) begin
        r_x1[i] <= '0;
        r_x2[i] <= '0;
        r_y1[i] <= '0;
        r_y2[i] <= '0;
      end
      for (int i = 0; i < NC; i++) begin
        r_coef[i] <= ((i % 5) == 0) ? ONE : '0;
      end
    end else begin
      r_ack <= w_req;
      if (w_req && !wb_we_i) r_dat <= w_rdata;
      if (w_wr && w_sel_x && !w_busy) r_x <= wb_dat_i;
      if (w_wr && w_sel_ctrl) begin
        r_enable <= wb_dat_i[0];
        r_irq_en <= wb_dat_i[2];
      end
      if (w_wr && w_sel_coef && !w_busy) r_coef[w_bus_cidx] <= COEFF_WIDTH'(wb_dat_i);

      // Flag sets take priority over a simultaneous STATUS clear.
      r_done    <= (r_done    & ~w_stat_clr) | w_done_set;
      r_drop    <= (r_drop    & ~w_stat_clr) | w_drop_set;
      r_cfg_err <= (r_cfg_err & ~w_stat_clr) | w_cfg_set;
      r_ovf     <= (r_ovf & ~{NUM_SECTIONS{w_stat_clr}}) | w_ovf_set;

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_MAC;
            r_s     <= '0;
            r_k     <= '0;
            r_acc   <= '0;
          end
        end
        S_MAC: begin
          r_acc <= w_acc_next;
          if (r_k == 3'd4) begin
            r_k     <= '0;
            r_state <= S_SAT;
          end else begin
            r_k <= r_k + 3'd1;
          end
        end
        S_SAT: begin
          r_x2[r_s] <= r_x1[r_s];
          r_x1[r_s] <= w_xin;
          r_y2[r_s] <= r_y1[r_s];
          r_y1[r_s] <= w_sat;
          r_acc     <= '0;
          if (r_s == LAST) begin
            r_state <= S_DONE;
          end else begin
            r_s     <= r_s + SW'(1);
            r_state <= S_MAC;
          end
        end
        default: begin
          r_y     <= r_y1[LAST];
          r_state <= S_IDLE;
        end
      endcase

      if (w_clr_state) begin
        r_state <= S_IDLE;
        r_s     <= '0;
        r_k     <= '0;
        r_acc   <= '0;
        for (int i = 0; i < NUM_SECTIONS; i++) begin
          r_x1[i] <= '0;
          r_x2[i] <= '0;
          r_y1[i] <= '0;
          r_y2[i] <= '0;
        end
      end
    end
  end

  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_dat;
  assign irq_o    = r_done & r_irq_en;

endmodule

// File: tb/tb_iir_sos_tdm_wb.sv
// tb/tb_iir_sos_tdm_wb.sv - directed bench for iir_sos_tdm_wb with a register table and multi-cycle sequences
module tb_iir_sos_tdm_wb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_we_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_ack_o;
  logic        irq_o;

  int n_pass = 0;
  int n_total = 0;

  iir_sos_tdm_wb dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_we_i  (wb_we_i),
    .wb_stb_i (wb_stb_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_ack_o (wb_ack_o),
    .irq_o    (irq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [7:0]  adr;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [0:20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic xfer(input logic we, input logic [7:0] adr, input logic [31:0] dat,
                      output logic [31:0] rd);
    int n;
    wb_adr_i = adr;
    wb_dat_i = dat;
    wb_we_i  = we;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wb_ack_o && n < 16);
    if (!wb_ack_o) begin
      n_total++;
      $display("FAIL ack_timeout: adr 0x%02h no ack after %0d cycles", adr, n);
    end
    rd = wb_dat_o;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  task automatic wr(input logic [7:0] adr, input logic [31:0] dat);
    logic [31:0] dummy;
    xfer(1'b1, adr, dat, dummy);
  endtask

  task automatic rd(input logic [7:0] adr, output logic [31:0] d);
    xfer(1'b0, adr, 32'h0, d);
  endtask

  task automatic wait_irq(output int cnt);
    cnt = 0;
    while (!irq_o && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    if (!irq_o) begin
      n_total++;
      $display("FAIL irq_timeout: irq_o low after %0d cycles", cnt);
    end
  endtask

  task automatic poll_done(output logic [31:0] st);
    int n;
    n = 0;
    do begin
      rd(8'h08, st);
      n++;
    end while (!st[1] && n < 60);
    if (!st[1]) begin
      n_total++;
      $display("FAIL done_timeout: STATUS 0x%08h after %0d polls", st, n);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int          cnt;

    vecs[0]  = '{1'b0, 8'h00, 32'h0,        32'h0};
    vecs[1]  = '{1'b0, 8'h04, 32'h0,        32'h0};
    vecs[2]  = '{1'b0, 8'h08, 32'h0,        32'h0};
    vecs[3]  = '{1'b0, 8'h0C, 32'h0,        32'h1};
    vecs[4]  = '{1'b0, 8'h10, 32'h0,        32'h0010_0000};
    vecs[5]  = '{1'b0, 8'h14, 32'h0,        32'h0};
    vecs[6]  = '{1'b0, 8'h24, 32'h0,        32'h0010_0000};
    vecs[7]  = '{1'b0, 8'h38, 32'h0,        32'h0010_0000};
    vecs[8]  = '{1'b0, 8'h48, 32'h0,        32'h0};
    vecs[9]  = '{1'b0, 8'h4C, 32'h0,        32'h0};
    vecs[10] = '{1'b1, 8'h4C, 32'h1234,     32'h0};
    vecs[11] = '{1'b0, 8'h4C, 32'h0,        32'h0};
    vecs[12] = '{1'b1, 8'h0C, 32'h7,        32'h0};
    vecs[13] = '{1'b0, 8'h0C, 32'h0,        32'h5};
    vecs[14] = '{1'b1, 8'h0C, 32'h1,        32'h0};
    vecs[15] = '{1'b0, 8'h0C, 32'h0,        32'h1};
    vecs[16] = '{1'b1, 8'h14, 32'hDEADBEEF, 32'h0};
    vecs[17] = '{1'b0, 8'h14, 32'h0,        32'hDEADBEEF};
    vecs[18] = '{1'b1, 8'h14, 32'h0,        32'h0};
    vecs[19] = '{1'b0, 8'h14, 32'h0,        32'h0};
    vecs[20] = '{1'b0, 8'h02, 32'h0,        32'h0};

    idle_cycles(3);
    chk("reset_ack", {31'h0, wb_ack_o}, 32'h0);
    chk("reset_irq", {31'h0, irq_o}, 32'h0);
    rst_n = 1'b1;
    idle_cycles(2);

    for (int i = 0; i < 21; i++) begin
      if (vecs[i].we) begin
        wr(vecs[i].adr, vecs[i].dat);
      end else begin
        rd(vecs[i].adr, d);
        chk($sformatf("vec%0d_adr%02h", i, vecs[i].adr), d, vecs[i].exp);
      end
    end
    @(negedge clk);
    chk("ack_single_pulse", {31'h0, wb_ack_o}, 32'h0);

    // passthrough, polled
    wr(8'h00, 32'd1000);
    rd(8'h08, d);
    chk("t1_busy", d, 32'h1);
    poll_done(d);
    chk("t1_done_status", d, 32'h2);
    rd(8'h04, d);
    chk("t1_y", d, 32'd1000);
    rd(8'h08, d);
    chk("t1_done_cleared", d, 32'h0);

    // gain 2 on section 0, latency measured on irq_o
    wr(8'h10, 32'h0020_0000);
    wr(8'h0C, 32'h5);
    wr(8'h00, 32'd1000);
    wait_irq(cnt);
    chk("t2_latency", cnt, 32'd19);
    rd(8'h04, d);
    chk("t2_y", d, 32'd2000);
    rd(8'h08, d);
    chk("t2_status", d, 32'h2);
    chk("t2_irq_fall", {31'h0, irq_o}, 32'h0);

    // one-pole feedback y = x + 0.5*y1 after an idle state clear
    wr(8'h10, 32'h0010_0000);
    wr(8'h1C, 32'hFFF8_0000);
    wr(8'h0C, 32'h7);
    wr(8'h00, 32'd1048576);
    wait_irq(cnt);
    rd(8'h04, d);
    chk("t3_y0", d, 32'd1048576);
    rd(8'h08, d);
    wr(8'h00, 32'd0);
    wait_irq(cnt);
    rd(8'h04, d);
    chk("t3_y1", d, 32'd524288);
    rd(8'h08, d);
    wr(8'h00, 32'd0);
    wait_irq(cnt);
    rd(8'h04, d);
    chk("t3_y2", d, 32'd262144);
    rd(8'h08, d);

    // saturation at both rails
    wr(8'h1C, 32'h0);
    wr(8'h10, 32'h0020_0000);
    wr(8'h00, 32'h7FFF_FFFF);
    wait_irq(cnt);
    rd(8'h04, d);
    chk("t4_y_pos", d, 32'h7FFF_FFFF);
    rd(8'h08, d);
    chk("t4_status_pos", d, 32'h102);
    wr(8'h00, 32'h8000_0000);
    wait_irq(cnt);
    rd(8'h04, d);
    chk("t4_y_neg", d, 32'h8000_0000);
    rd(8'h08, d);
    chk("t4_status_neg", d, 32'h102);

    // drop and coefficient guard while busy
    wr(8'h10, 32'h0010_0000);
    wr(8'h00, 32'd500);
    wr(8'h00, 32'd700);
    wr(8'h14, 32'h0001_2345);
    wait_irq(cnt);
    rd(8'h08, d);
    chk("t5_status", d, 32'hE);
    rd(8'h04, d);
    chk("t5_y", d, 32'd500);
    rd(8'h00, d);
    chk("t5_x", d, 32'd500);
    rd(8'h14, d);
    chk("t5_b1", d, 32'h0);

    // abort by state clear while busy
    wr(8'h00, 32'd300);
    wr(8'h0C, 32'h7);
    idle_cycles(40);
    chk("t6_no_irq", {31'h0, irq_o}, 32'h0);
    rd(8'h08, d);
    chk("t6_status", d, 32'h0);
    rd(8'h04, d);
    chk("t6_y", d, 32'd500);

    // sample loads but nothing runs with ENABLE=0
    wr(8'h0C, 32'h4);
    wr(8'h00, 32'd77);
    rd(8'h08, d);
    chk("t7_not_busy", d, 32'h0);
    idle_cycles(40);
    rd(8'h00, d);
    chk("t7_x", d, 32'd77);
    rd(8'h04, d);
    chk("t7_y", d, 32'd500);

    // asynchronous reset mid-MAC
    wr(8'h0C, 32'h5);
    wr(8'h10, 32'h0030_0000);
    wr(8'h00, 32'd10);
    idle_cycles(2);
    rst_n = 1'b0;
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(40);
    chk("t8_irq", {31'h0, irq_o}, 32'h0);
    rd(8'h04, d);
    chk("t8_y", d, 32'h0);
    rd(8'h10, d);
    chk("t8_b0", d, 32'h0010_0000);
    rd(8'h0C, d);
    chk("t8_ctrl", d, 32'h1);
    rd(8'h08, d);
    chk("t8_status", d, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
